// File: rtl/spi_master_rx.sv
// spi_master_rx: SPI master that clocks one BITS-long frame in from a slave
// per start request and hands it to a valid/ready consumer.
// Optional feature: define SPI_RX_MISO_INV_EN to shift in the inverse of
// miso at every sample point (default build shifts miso in unmodified).
module spi_master_rx #(
   parameter int   BITS      = 8,
   parameter int   DIV       = 2,
   parameter logic CPOL      = 1'b1,
   parameter logic CPHA      = 1'b1,
   parameter logic LSB_FIRST = 1'b0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            miso,
   output logic            sck,
   output logic            cs,
   output logic            busy,
   output logic [BITS-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            overrun
);

   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int EDGE_W = $clog2(2 * BITS + 1);

   localparam logic [DIV_W-1:0]  DIV_ZERO  = DIV_W'(1'b0);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1'b1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_ZERO = EDGE_W'(1'b0);
   localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1'b1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * BITS);
   localparam logic [BITS-1:0]   WORD_ZERO = BITS'(1'b0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [DIV_W-1:0]  div_r, div_s;
   logic [EDGE_W-1:0] edge_r, edge_s;
   logic [BITS-1:0]   shift_r, shift_s;
   logic [BITS-1:0]   rx_data_r, rx_data_s;
   logic              sck_r, sck_s;
   logic              cs_r, cs_s;
   logic              busy_r, busy_s;
   logic              rx_valid_r, rx_valid_s;
   logic              overrun_r, overrun_s;
   logic              tick_s;

   // Bit actually shifted in at a sample point (optionally inverted miso).
   function automatic logic sample_bit(input logic d);
`ifdef SPI_RX_MISO_INV_EN
      return ~d;
`else
      return d;
`endif
   endfunction

   // Insert one received bit in the configured shift direction.
   function automatic logic [BITS-1:0] shift_in(input logic [BITS-1:0] cur, input logic b);
      if (LSB_FIRST) begin
         return {b, cur[BITS-1:1]};
      end else begin
         return {cur[BITS-2:0], b};
      end
   endfunction

   // Next-state, counter, shifter and output decode.
   always_comb begin
      state_s   = state_r;
      div_s     = div_r;
      edge_s    = edge_r;
      shift_s   = shift_r;
      sck_s     = sck_r;
      cs_s      = cs_r;
      rx_data_s = rx_data_r;
      overrun_s = 1'b0;
      tick_s    = (div_r == DIV_LAST);

      // Consumer handshake; a completion below may set it again.
      if (rx_valid_r && rx_ready) begin
         rx_valid_s = 1'b0;
      end else begin
         rx_valid_s = rx_valid_r;
      end

      case (state_r)
         IDLE: begin
            div_s  = DIV_ZERO;
            edge_s = EDGE_ZERO;
            sck_s  = CPOL;
            if (start) begin
               state_s = XFER;
               cs_s    = 1'b0;
               shift_s = WORD_ZERO;
            end else begin
               state_s = IDLE;
               cs_s    = 1'b1;
            end
         end
         XFER: begin
            if (tick_s) begin
               div_s  = DIV_ZERO;
               sck_s  = ~sck_r;
               edge_s = edge_r + EDGE_ONE;
               // Even edge_r means the toggle about to happen is a leading one.
               if (edge_r[0] == CPHA) begin
                  shift_s = shift_in(shift_r, sample_bit(miso));
               end else begin
                  shift_s = shift_r;
               end
               if (edge_r == (EDGE_LAST - EDGE_ONE)) begin
                  state_s = HOLD;
               end else begin
                  state_s = XFER;
               end
            end else begin
               div_s = div_r + DIV_ONE;
            end
         end
         HOLD: begin
            if (tick_s) begin
               div_s      = DIV_ZERO;
               edge_s     = EDGE_ZERO;
               cs_s       = 1'b1;
               rx_data_s  = shift_r;
               overrun_s  = rx_valid_r && !rx_ready;
               rx_valid_s = 1'b1;
               state_s    = IDLE;
            end else begin
               div_s = div_r + DIV_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            div_s   = DIV_ZERO;
            edge_s  = EDGE_ZERO;
            sck_s   = CPOL;
            cs_s    = 1'b1;
         end
      endcase

      busy_s = (state_s != IDLE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         div_r      <= DIV_ZERO;
         edge_r     <= EDGE_ZERO;
         shift_r    <= WORD_ZERO;
         rx_data_r  <= WORD_ZERO;
         sck_r      <= CPOL;
         cs_r       <= 1'b1;
         busy_r     <= 1'b0;
         rx_valid_r <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         div_r      <= div_s;
         edge_r     <= edge_s;
         shift_r    <= shift_s;
         rx_data_r  <= rx_data_s;
         sck_r      <= sck_s;
         cs_r       <= cs_s;
         busy_r     <= busy_s;
         rx_valid_r <= rx_valid_s;
         overrun_r  <= overrun_s;
      end
   end

   assign sck      = sck_r;
   assign cs       = cs_r;
   assign busy     = busy_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign overrun  = overrun_r;

endmodule

// File: tb/tb_spi_master_rx.sv
// tb_spi_master_rx: three spi_master_rx configurations, each driven by a
// behavioural SPI slave, checked against cycle numbers and words derived
// from the SPI mode rules.
module tb_spi_master_rx;

   localparam int N    = 3;
   localparam int BITS = 8;
   // Instance 0: DIV2 mode 3 MSB, 1: DIV2 mode 3 LSB, 2: DIV1 mode 0 MSB.
   localparam logic [23:0]  DIV_V  = {8'd1, 8'd2, 8'd2};
   localparam logic [N-1:0] CPOL_V = 3'b011;
   localparam logic [N-1:0] CPHA_V = 3'b011;
   localparam logic [N-1:0] LSB_V  = 3'b010;
`ifdef SPI_RX_MISO_INV_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   logic            clk;
   logic            reset_n;
   logic [N-1:0]    start;
   logic [N-1:0]    sck;
   logic [N-1:0]    cs;
   logic [N-1:0]    busy;
   logic [N-1:0]    rx_valid;
   logic [N-1:0]    rx_ready;
   logic [N-1:0]    overrun;
   logic [BITS-1:0] rx_data [N];
   logic [BITS-1:0] tx_word [N];
   logic [N-1:0]    pend;

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int P_DIV = int'(DIV_V[g*8 +: 8]);
      logic miso_g = 1'b0;
      logic cs_q   = 1'b1;
      logic sck_q  = CPOL_V[g];
      int   idx    = 0;

      spi_master_rx #(
         .BITS(BITS), .DIV(P_DIV), .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g]), .LSB_FIRST(LSB_V[g])
      ) u_dut (
         .clk(clk), .reset_n(reset_n), .start(start[g]), .miso(miso_g),
         .sck(sck[g]), .cs(cs[g]), .busy(busy[g]), .rx_data(rx_data[g]),
         .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]), .overrun(overrun[g])
      );

      // j-th bit on the wire for the word this slave is sending.
      function automatic logic bit_at(input int j);
         logic [BITS-1:0] w;
         w = tx_word[g];
         if (j >= BITS) return 1'b0;
         if (LSB_V[g]) return w[j];
         return w[BITS-1-j];
      endfunction

      // Slave: mode 0 presents a bit at cs fall and after each trailing edge,
      // mode 1 presents a bit at each leading edge.
      always @(cs[g] or sck[g]) begin
         if (cs_q && !cs[g]) begin
            idx    = 0;
            miso_g = bit_at(0);
         end else if (!cs[g] && (sck[g] !== sck_q)) begin
            if (sck[g] !== CPOL_V[g]) begin
               if (CPHA_V[g]) begin
                  miso_g = bit_at(idx);
                  idx    = idx + 1;
               end
            end else begin
               if (!CPHA_V[g]) begin
                  idx    = idx + 1;
                  miso_g = bit_at(idx);
               end
            end
         end
         cs_q  = cs[g];
         sck_q = sck[g];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int div_of(input int g);
      return int'(DIV_V[g*8 +: 8]);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // mode 0 plain, 1 rx_ready in completion cycle, 2 extra start mid-frame,
   // 3 reset at toggle 7.
   task automatic run_frame(input int g, input logic [BITS-1:0] word, input int mode);
      int   d, c, tog, ovr, cs_rise;
      logic prev_sck, done, pulsed, exp_ovr;
      d       = div_of(g);
      cs_rise = 1 + d * (2 * BITS + 1);
      exp_ovr = pend[g] && (mode != 1);
      tx_word[g] = word;
      start[g]   = 1'b1;
      @(posedge clk); #1;
      start[g] = 1'b0;
      c = 1;
      check("cs_fall_cycle1", cs[g], 1'b0);
      check("sck_idle_at_cs_fall", sck[g], CPOL_V[g]);
      check("busy_in_frame", busy[g], 1'b1);
      tog = 0; ovr = 0; done = 1'b0; pulsed = 1'b0;
      prev_sck = sck[g];
      while (!done && c < 400) begin
         if (mode == 1 && c == cs_rise - 1) rx_ready[g] = 1'b1;
         if (mode == 2 && tog == 3 && !pulsed) begin
            start[g] = 1'b1;
            pulsed   = 1'b1;
         end else begin
            start[g] = 1'b0;
         end
         @(posedge clk); #1;
         c++;
         rx_ready[g] = 1'b0;
         if (overrun[g] === 1'b1) ovr++;
         if (sck[g] !== prev_sck) begin
            tog++;
            prev_sck = sck[g];
            check("sck_toggle_cycle", c, 1 + d * tog);
         end
         if (mode == 3 && tog == 7) begin
            #1 reset_n = 1'b0;
            #1;
            check("rst_cs", cs[g], 1'b1);
            check("rst_sck", sck[g], CPOL_V[g]);
            check("rst_busy", busy[g], 1'b0);
            check("rst_rx_valid", rx_valid[g], 1'b0);
            check("rst_rx_data", rx_data[g], '0);
            check("rst_overrun", overrun[g], 1'b0);
            pend = '0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            return;
         end
         if (cs[g] === 1'b1) begin
            done = 1'b1;
            check("cs_rise_cycle", c, cs_rise);
            check("overrun_at_completion", overrun[g], exp_ovr);
         end
      end
      check("frame_finished_in_budget", done, 1'b1);
      check("toggle_count", tog, 2 * BITS);
      check("rx_data", rx_data[g], INV ? ~word : word);
      check("rx_valid_after_frame", rx_valid[g], 1'b1);
      check("busy_after_frame", busy[g], 1'b0);
      check("sck_idle_after_frame", sck[g], CPOL_V[g]);
      @(posedge clk); #1;
      if (overrun[g] === 1'b1) ovr++;
      check("overrun_pulse_count", ovr, exp_ovr);
      pend[g] = 1'b1;
      if (mode == 2) begin
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("no_queued_start", {busy[g], cs[g]}, 2'b01);
         end
      end
   endtask

   task automatic consume(input int g);
      rx_ready[g] = 1'b1;
      @(posedge clk); #1;
      rx_ready[g] = 1'b0;
      pend[g]     = 1'b0;
      check("rx_valid_cleared", rx_valid[g], 1'b0);
   endtask

   initial begin
      logic [BITS-1:0] w;
      int              g;
      reset_n  = 1'b0;
      start    = '0;
      rx_ready = '0;
      pend     = '0;
      for (int i = 0; i < N; i++) tx_word[i] = '0;
      #12;
      for (int i = 0; i < N; i++) begin
         check("reset_cs", cs[i], 1'b1);
         check("reset_sck", sck[i], CPOL_V[i]);
         check("reset_busy", busy[i], 1'b0);
         check("reset_rx_valid", rx_valid[i], 1'b0);
         check("reset_rx_data", rx_data[i], '0);
         check("reset_overrun", overrun[i], 1'b0);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;

      run_frame(0, 8'hA5, 0);
      consume(0);
      run_frame(1, 8'hA5, 0);
      consume(1);
      run_frame(2, 8'h3C, 0);
      consume(2);

      run_frame(0, 8'h11, 0);
      run_frame(0, 8'h22, 0);
      consume(0);

      w = BITS'($urandom);
      run_frame(0, w, 0);
      w = BITS'($urandom);
      run_frame(0, w, 1);
      consume(0);

      w = BITS'($urandom);
      run_frame(0, w, 2);
      consume(0);

      w = BITS'($urandom);
      run_frame(0, w, 3);
      w = BITS'($urandom);
      run_frame(0, w, 0);
      consume(0);

      for (int i = 0; i < 8; i++) begin
         g = int'($urandom_range(0, N - 1));
         w = BITS'($urandom);
         run_frame(g, w, 0);
         if ($urandom_range(0, 1) == 1) consume(g);
      end
      for (int i = 0; i < N; i++) consume(i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_master_rx.md
SPI_MASTER_RX -- requirements
Module: spi_master_rx

Interface
REQ-001 SHALL have parameter BITS, default 8, frame length in bits (legal range 2..32).
REQ-002 SHALL have parameter DIV, default 2, clk cycles per SCK half-period (legal range 1..255).
REQ-003 SHALL have parameter CPOL, default 1, SCK idle level.
REQ-004 SHALL have parameter CPHA, default 1: 0 samples on leading edge, 1 samples on trailing edge.
REQ-005 SHALL have parameter LSB_FIRST, default 0: 0 shifts MSB-first, 1 shifts LSB-first.
REQ-006 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-007 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, request one frame; sampled only in IDLE.
REQ-009 SHALL have port miso, input, 1, serial data from the slave.
REQ-010 SHALL have port sck, output, 1, SPI clock.
REQ-011 SHALL have port cs, output, 1, chip select, active-low.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port rx_data, output, BITS, last completed word.
REQ-014 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-015 SHALL have port rx_ready, input, 1, consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-016 SHALL have port overrun, output, 1, one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-017 SHALL implement states IDLE, XFER and HOLD; the state, shift register, bit counter and divider counter are all registered.
REQ-018 SHALL, in IDLE with start high, enter XFER on the next edge: cs=0, divider=0, edge count=0.
REQ-019 SHALL ignore start while busy; it SHALL NOT queue the request.
REQ-020 SHALL assert a tick when divider==DIV-1; the divider SHALL then wrap to 0.
REQ-021 SHALL toggle sck on each XFER tick, 2*BITS toggles per frame: odd toggles drive !CPOL (leading), even toggles drive CPOL (trailing).
REQ-022 SHALL sample miso at the leading tick (CPHA=0) or the trailing tick (CPHA=1).
REQ-023 SHALL shift MSB-first by shifting left and inserting at bit 0, or LSB-first by shifting right and inserting at bit BITS-1.
REQ-024 SHALL enter HOLD after the 2*BITS-th toggle; on the next tick it SHALL set cs=1, load rx_data, set rx_valid=1 and return to IDLE.
REQ-025 SHALL give the following timing, with the start-accept edge as cycle 0: cs falls at cycle 1, sck toggle k is visible at cycle 1+DIV*k, cs rises at cycle 1+DIV*(2*BITS+1).
REQ-026 SHALL clear rx_valid on a handshake that has no simultaneous completion.
REQ-027 SHALL, on completion with rx_valid=1 and rx_ready=0, overwrite rx_data, keep rx_valid=1 and pulse overrun.
REQ-028 SHALL, on completion in the same cycle as a handshake, load the new word and keep rx_valid=1, with no overrun.
REQ-029 SHALL allow a new start while rx_valid is pending.
REQ-030 SHALL hold sck=CPOL and cs=1 throughout IDLE.

Reset
REQ-031 SHALL, on reset_n low at any time (including mid-frame), immediately force cs=1, sck=CPOL, busy=0, rx_valid=0, rx_data=0, overrun=0, state=IDLE and all counters to 0.
REQ-032 SHALL discard any partial frame at reset and SHALL accept start on the first clk edge after reset_n rises.

Configuration
REQ-033 SHALL, with macro SPI_RX_MISO_INV_EN defined, shift in the inverse of miso at every sample point.
REQ-034 SHALL, with SPI_RX_MISO_INV_EN undefined, shift in miso unmodified; this is the default build.

Verification
REQ-035 SHALL cover: BITS=8, DIV=2, CPOL=1, CPHA=1, slave sends 0xA5, start pulse -> cs low cycle 1, 16 sck toggles, cs high cycle 35, rx_data=0xA5, rx_valid=1.
REQ-036 SHALL cover: same stimulus with LSB_FIRST=1 -> rx_data=0xA5 for a slave sending LSB first; with SPI_RX_MISO_INV_EN defined and MSB first -> rx_data=0x5A.
REQ-037 SHALL cover: CPOL=0, CPHA=0, DIV=1, slave sends 0x3C -> sck idles 0, samples taken on rising edges, rx_data=0x3C, cs high cycle 18.
REQ-038 SHALL cover: two frames 0x11 then 0x22 with rx_ready=0 -> overrun pulses once at the second completion, rx_data=0x22, rx_valid=1.
REQ-039 SHALL cover: rx_ready=1 in the completion cycle with rx_valid pending -> rx_valid stays 1, rx_data holds the new word, no overrun.
REQ-040 SHALL cover: reset_n low at toggle 7 -> cs=1 and sck=CPOL without waiting for a clk edge; a following start yields a clean frame.
